fifo_rd_arbiter: RTL and testbench

Read-side scheduler for the shared encapsulation FIFO: round-robin arbitration among NUM_REQ requesters, each requesting a burst of req_len words. Grants one requester at a time and drives the FIFO read enable only while the FIFO is non-empty. Returns data tagged with the requester ID and a last-word flag. Sits between the FIFO read port (rd_en/empty/data) and the frame-assembly consumers.

---
 rtl/fifo_rd_arbiter_if.sv | 41 ++++
 rtl/fifo_rd_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if
//   Bundles the requester handshake, FIFO read port and tagged output
//   stream of the read-side FIFO arbiter.
//   Signals:
//     req/req_len       requester level requests and burst lengths
//     gnt               one-hot grant, high for the whole burst
//     fifo_empty        FIFO empty flag
//     fifo_rd_en        FIFO pop strobe
//     fifo_rd_data      FIFO data, valid the cycle after a pop
//     out_data/out_valid/out_id/out_last/busy   tagged output stream
//   Modports:
//     slave   arbiter side
//     master  environment side (requesters, FIFO, consumers)
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_empty;
  logic                     fifo_rd_en;
  logic [DATA_W-1:0]        fifo_rd_data;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic [ID_W-1:0]          out_id;
  logic                     out_last;
  logic                     busy;

  modport slave (
    input  req, req_len, fifo_empty, fifo_rd_data,
    output gnt, fifo_rd_en, out_data, out_valid, out_id, out_last, busy
  );

  modport master (
    output req, req_len, fifo_empty, fifo_rd_data,
    input  gnt, fifo_rd_en, out_data, out_valid, out_id, out_last, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Round-robin read scheduler for the shared encapsulation FIFO. One
//   requester at a time is granted a burst of req_len words; the FIFO is
//   popped only while non-empty and the words are returned tagged with the
//   requester ID and a last-word flag.
//   Ports:
//     rclk      read-domain clock, rising edge
//     rd_srstn  asynchronous active-low reset
//     bus       fifo_rd_arbiter_if.slave (requests, FIFO port, output stream)
module fifo_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               rclk,
  input  logic               rd_srstn,
  fifo_rd_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               out_valid_q;
  logic               out_last_q;

  logic                 rd_en;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 pick_vld;
  logic [ID_W:0]        pick_off;
  logic [ID_W:0]        pick_sum;
  logic [ID_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [LEN_W-1:0]     pick_len;

  // Rotate requests so that bit 0 is the requester at rr_ptr; the lowest
  // set bit of the rotated vector is then the round-robin winner.
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = NUM_REQ'(req_dbl >> rr_ptr_q);

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_off = (ID_W+1)'(k);
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr_q} + pick_off;
  assign pick_idx = (pick_sum >= NUM_REQ_W) ? ID_W'(pick_sum - NUM_REQ_W)
                                            : ID_W'(pick_sum);

  always_comb begin
    pick_onehot = '0;
    pick_len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        pick_onehot[i] = 1'b1;
        pick_len       = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Pop only in READ with words outstanding and data available.
  assign rd_en = (state_q == S_READ) && (rem_q != '0) && !bus.fifo_empty;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_READ;
          gnt_d   = pick_onehot;
          id_d    = pick_idx;
          rem_d   = pick_len;
        end
      end
      S_READ: begin
        if (rem_q == '0) begin
          // Zero-length burst: finish without popping.
          state_d = S_DONE;
        end else if (rd_en) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (id_q == LAST_IDX) ? '0 : id_q + ID_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rd_srstn) begin
    if (!rd_srstn) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      rem_q       <= rem_d;
      out_valid_q <= rd_en;
      out_last_q  <= rd_en && (rem_q == LEN_W'(1));
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = bus.fifo_rd_data;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = id_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;

  logic rclk = 1'b0;
  logic rd_srstn = 1'b0;

  fifo_rd_arbiter_if #(.NUM_REQ(4), .LEN_W(8), .DATA_W(8), .ID_W(2)) bus ();

  fifo_rd_arbiter #(.NUM_REQ(4), .LEN_W(8), .DATA_W(8), .ID_W(2)) dut (
    .rclk     (rclk),
    .rd_srstn (rd_srstn),
    .bus      (bus)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic        rd_en;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic [1:0]  id;
    logic        busy;
  } vec_t;

  vec_t tv[14];
  logic [7:0] fq[$];
  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    bus.fifo_empty = 1'b0;
    #1;
  endtask

  // One clock: the FIFO model pops on the edge where fifo_rd_en was high,
  // and presents the popped word just after that edge.
  task automatic tick();
    logic en;
    #1;
    en = bus.fifo_rd_en;
    @(posedge rclk);
    #1;
    if (en && fq.size() > 0) bus.fifo_rd_data = fq.pop_front();
    bus.fifo_empty = (fq.size() == 0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    bit done;
    bus.req = '0;
    bus.req_len = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = '0;

    // single burst (rows 0..4), zero-length and priority after it (rows 5..13)
    tv[0]  = '{4'b0001, 32'h3, 4'b0001, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    tv[1]  = '{4'b0000, 32'h3, 4'b0001, 1'b1, 1'b1, 8'hA1, 1'b0, 2'd0, 1'b1};
    tv[2]  = '{4'b0000, 32'h3, 4'b0001, 1'b1, 1'b1, 8'hA2, 1'b0, 2'd0, 1'b1};
    tv[3]  = '{4'b0000, 32'h3, 4'b0001, 1'b0, 1'b1, 8'hA3, 1'b1, 2'd0, 1'b1};
    tv[4]  = '{4'b0000, 32'h3, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tv[5]  = '{4'b0100, 32'h0, 4'b0100, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1};
    tv[6]  = '{4'b0000, 32'h0, 4'b0100, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1};
    tv[7]  = '{4'b1001, 32'h0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0};
    tv[8]  = '{4'b1001, 32'h0, 4'b1000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b1};
    tv[9]  = '{4'b0001, 32'h0, 4'b1000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b1};
    tv[10] = '{4'b0001, 32'h0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0};
    tv[11] = '{4'b0001, 32'h0, 4'b0001, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    tv[12] = '{4'b0000, 32'h0, 4'b0001, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    tv[13] = '{4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

    // reset state
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_id", bus.out_id, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    #2 rd_srstn = 1'b1;

    push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 14; i++) begin
      bus.req = tv[i].req;
      bus.req_len = tv[i].len;
      tick();
      chk($sformatf("tv%0d_gnt", i), bus.gnt, tv[i].gnt);
      chk($sformatf("tv%0d_rd_en", i), bus.fifo_rd_en, tv[i].rd_en);
      chk($sformatf("tv%0d_valid", i), bus.out_valid, tv[i].valid);
      chk($sformatf("tv%0d_last", i), bus.out_last, tv[i].last);
      chk($sformatf("tv%0d_id", i), bus.out_id, tv[i].id);
      chk($sformatf("tv%0d_busy", i), bus.busy, tv[i].busy);
      if (tv[i].valid) chk($sformatf("tv%0d_data", i), bus.out_data, tv[i].data);
    end

    // empty stall: rr_ptr is 1, requester 1 asks for 4 words, 2 available
    bus.req = 4'b0010;
    bus.req_len = 32'h0000_0400;
    push(8'hC1); push(8'hC2);
    tick();
    bus.req = 4'b0000;
    chk("stall_gnt0", bus.gnt, 4'b0010);
    nv = 0;
    done = 1'b0;
    for (int c = 1; c <= 30 && !done; c++) begin
      tick();
      chk($sformatf("stall_nopop_c%0d", c), bus.fifo_rd_en && bus.fifo_empty, 0);
      chk($sformatf("stall_gnt_c%0d", c), bus.gnt, 4'b0010);
      if (bus.out_valid) begin
        nv++;
        chk($sformatf("stall_data%0d", nv), bus.out_data, 8'hC0 + nv);
        chk($sformatf("stall_last%0d", nv), bus.out_last, (nv == 4));
        chk($sformatf("stall_id%0d", nv), bus.out_id, 1);
        if (bus.out_last) done = 1'b1;
      end
      if (c == 5) push(8'hC3);
      if (c == 7) push(8'hC4);
    end
    chk("stall_count", nv, 4);
    chk("stall_finished", done, 1);
    tick();
    chk("stall_gnt_end", bus.gnt, 0);

    // request drop and late arrival: rr_ptr is 2, only requester 1 asks
    bus.req = 4'b0010;
    bus.req_len = 32'h0000_0500;
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    tick();
    chk("drop_gnt", bus.gnt, 4'b0010);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk($sformatf("drop_valid%0d", k), bus.out_valid, 1);
      chk($sformatf("drop_id%0d", k), bus.out_id, 1);
      chk($sformatf("drop_data%0d", k), bus.out_data, 8'hD0 + (k - 2));
      chk($sformatf("drop_last%0d", k), bus.out_last, (k == 6));
      chk($sformatf("drop_gnt%0d", k), bus.gnt, 4'b0010);
      if (k == 3) bus.req = 4'b1001;
    end
    tick();
    chk("drop_idle_gnt", bus.gnt, 0);
    tick();
    chk("drop_next_gnt3", bus.gnt, 4'b1000);
    bus.req = 4'b0001;
    tick();
    tick();
    chk("drop_idle2_gnt", bus.gnt, 0);
    tick();
    chk("drop_next_gnt0", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    tick();
    tick();

    // asynchronous reset mid-burst with rem = 3
    bus.req = 4'b0010;
    bus.req_len = 32'h0000_0500;
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
    tick();
    bus.req = 4'b0000;
    tick();
    tick();
    chk("ar_pre_gnt", bus.gnt, 4'b0010);
    chk("ar_pre_rd_en", bus.fifo_rd_en, 1);
    #3 rd_srstn = 1'b0;
    #1;
    chk("ar_gnt", bus.gnt, 0);
    chk("ar_rd_en", bus.fifo_rd_en, 0);
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_last", bus.out_last, 0);
    fq.delete();
    bus.fifo_empty = 1'b1;
    @(posedge rclk);
    #2 rd_srstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("ar_idle_busy%0d", i), bus.busy, 0);
      chk($sformatf("ar_idle_gnt%0d", i), bus.gnt, 0);
    end

    // round robin: all request, length 1; rr_ptr restarted at 0
    bus.req_len = 32'h0101_0101;
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("rr%0d_gnt", g), bus.gnt, 4'b0001 << (g % 4));
      chk($sformatf("rr%0d_id", g), bus.out_id, g % 4);
      chk($sformatf("rr%0d_rd_en", g), bus.fifo_rd_en, 1);
      tick();
      chk($sformatf("rr%0d_gnt_done", g), bus.gnt, 4'b0001 << (g % 4));
      chk($sformatf("rr%0d_valid", g), bus.out_valid, 1);
      chk($sformatf("rr%0d_last", g), bus.out_last, 1);
      chk($sformatf("rr%0d_data", g), bus.out_data, 8'h50 + g);
      if (g == 4) bus.req = 4'b0000;
      tick();
      chk($sformatf("rr%0d_dead", g), bus.gnt, 0);
      chk($sformatf("rr%0d_dead_valid", g), bus.out_valid, 0);
    end
    tick();
    chk("rr_end_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
